// File: rtl/traffic_checker.sv
// -----------------------------------------------------------------------------
// traffic_checker
//
// Purpose:
//   Stimulus generator and output comparator for a pair of DUTs (behavioural
//   and structural). After an init pulse it sends cfg_words words on each of
//   NUM_PORTS independent ports. Each port has its own pause input for
//   backpressure. It then waits DRAIN_CYC cycles and reports DONE. In every
//   state, on each cycle with cmp_valid=1, it compares the two DUT output
//   buses port by port. Each differing port adds one to a saturating mismatch
//   counter, and any difference sets a sticky error flag.
//
// Data word layout (DATA_W bits per port):
//   [DATA_W-1]   VC bit: 0 while word index k < split, else 1
//   [DATA_W-2:0] payload: (p*PORT_OFFSET + k) mod 2^(DATA_W-1)
//
// Handshake: data_out slice p is meaningful only on cycles where
//   valid_out[p]=1. There is no ready. pause[p] is the only backpressure.
//   While a port is paused or has finished, valid_out[p] is 0 and its data
//   slice holds the last word sent.
//
// Ports:
//   clk            in   clock; all state changes on the rising edge
//   reset_L        in   asynchronous active-low reset
//   init           in   start pulse, accepted in IDLE and DONE only
//   cfg_words      in   words to send per port, latched in INIT
//   cfg_split      in   word index where the VC bit switches 0->1, latched in INIT
//   pause          in   per-port backpressure
//   cmp_valid      in   dut_a / dut_b are comparable this cycle
//   dut_a, dut_b   in   DUT output buses, port p at [p*DATA_W +: DATA_W]
//   data_out       out  stimulus words, port p at [p*DATA_W +: DATA_W]
//   valid_out      out  per-port word valid
//   busy           out  high in INIT, SEND, DRAIN
//   done           out  high in DONE
//   error          out  sticky: some compare found a difference
//   mismatch_cnt   out  saturating count of differing port-compares
//   fsm_state      out  current FSM state (debug visibility)
// -----------------------------------------------------------------------------
module traffic_checker #(
    parameter int DATA_W      = 6,
    parameter int NUM_PORTS   = 2,
    parameter int CNT_W       = 5,
    parameter int PORT_OFFSET = 13,
    parameter int DRAIN_CYC   = 4
) (
    input  logic                        clk,
    input  logic                        reset_L,
    input  logic                        init,
    input  logic [CNT_W-1:0]            cfg_words,
    input  logic [CNT_W-1:0]            cfg_split,
    input  logic [NUM_PORTS-1:0]        pause,
    input  logic                        cmp_valid,
    input  logic [NUM_PORTS*DATA_W-1:0] dut_a,
    input  logic [NUM_PORTS*DATA_W-1:0] dut_b,
    output logic [NUM_PORTS*DATA_W-1:0] data_out,
    output logic [NUM_PORTS-1:0]        valid_out,
    output logic                        busy,
    output logic                        done,
    output logic                        error,
    output logic [7:0]                  mismatch_cnt,
    output logic [2:0]                  fsm_state
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_INIT  = 3'd1;
    localparam logic [2:0] ST_SEND  = 3'd2;
    localparam logic [2:0] ST_DRAIN = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    localparam int PAY_W = DATA_W - 1;
    localparam int DRN_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
    localparam logic [DRN_W-1:0] DRAIN_LAST = DRN_W'(DRAIN_CYC - 1);

    logic [2:0]           state;
    logic [2:0]           state_nxt;
    logic [CNT_W-1:0]     words_q;
    logic [CNT_W-1:0]     split_q;
    logic [DRN_W-1:0]     drain_q;
    logic [NUM_PORTS-1:0] port_finished;
    logic                 all_sent;
    logic [3:0]           diff_cnt;
    logic [8:0]           cnt_sum;

    assign fsm_state = state;
    assign all_sent  = &port_finished;

    // -------------------------------------------------------------------------
    // Per-port word generators
    // -------------------------------------------------------------------------
    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        // Reducing the port base once means the payload add below wraps
        // naturally in PAY_W bits, which gives the modulo for free.
        localparam logic [PAY_W-1:0] BASE = PAY_W'(p * PORT_OFFSET);

        logic [CNT_W-1:0]  k;
        logic [DATA_W-1:0] data_q;
        logic              valid_q;
        logic              fire;
        logic [DATA_W-1:0] word;

        assign fire = (state == ST_SEND) && (k < words_q) && !pause[p];
        assign word = {(k >= split_q), BASE + PAY_W'(k)};

        always_ff @(posedge clk or negedge reset_L) begin
            if (!reset_L) begin
                k       <= '0;
                data_q  <= '0;
                valid_q <= 1'b0;
            end else begin
                valid_q <= fire;
                if (state == ST_INIT) begin
                    k <= '0;
                end else if (fire) begin
                    k      <= k + CNT_W'(1);
                    data_q <= word;
                end
            end
        end

        assign port_finished[p]              = (k == words_q);
        assign data_out[p*DATA_W +: DATA_W]  = data_q;
        assign valid_out[p]                  = valid_q;
    end

    // -------------------------------------------------------------------------
    // FSM
    // -------------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (init) state_nxt = ST_INIT;
            // The decision uses cfg_words directly. It is the same value being
            // latched on this edge.
            ST_INIT:  state_nxt = (cfg_words != '0) ? ST_SEND : ST_DRAIN;
            ST_SEND:  if (all_sent) state_nxt = ST_DRAIN;
            ST_DRAIN: if (drain_q == DRAIN_LAST) state_nxt = ST_DONE;
            ST_DONE:  if (init) state_nxt = ST_INIT;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state   <= ST_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            words_q <= '0;
            split_q <= '0;
            drain_q <= '0;
        end else begin
            state <= state_nxt;
            // busy/done are registered from the next state so that they line
            // up with the state register rather than lagging it.
            busy  <= (state_nxt == ST_INIT) || (state_nxt == ST_SEND) ||
                     (state_nxt == ST_DRAIN);
            done  <= (state_nxt == ST_DONE);
            if (state == ST_INIT) begin
                words_q <= cfg_words;
                split_q <= cfg_split;
            end
            drain_q <= (state == ST_DRAIN) ? drain_q + DRN_W'(1) : '0;
        end
    end

    // -------------------------------------------------------------------------
    // Comparator
    // -------------------------------------------------------------------------
    always_comb begin
        diff_cnt = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (dut_a[p*DATA_W +: DATA_W] != dut_b[p*DATA_W +: DATA_W]) begin
                diff_cnt = diff_cnt + 4'd1;
            end
        end
    end

    // At most 255 + 8 fits in 9 bits, so bit 8 set means the count saturated.
    assign cnt_sum = {1'b0, mismatch_cnt} + {5'd0, diff_cnt};

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            mismatch_cnt <= '0;
            error        <= 1'b0;
        end else if (state == ST_INIT) begin
            // The clear takes priority. A compare during INIT is dropped.
            mismatch_cnt <= '0;
            error        <= 1'b0;
        end else if (cmp_valid) begin
            mismatch_cnt <= cnt_sum[8] ? 8'hFF : cnt_sum[7:0];
            if (diff_cnt != 4'd0) begin
                error <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_traffic_checker.sv
module tb_traffic_checker;

    localparam int DATA_W    = 6;
    localparam int NUM_PORTS = 2;
    localparam int CNT_W     = 5;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_INIT  = 3'd1;
    localparam logic [2:0] S_SEND  = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                        reset_L = 1'b1;
    logic                        init = 1'b0;
    logic [CNT_W-1:0]            cfg_words = '0;
    logic [CNT_W-1:0]            cfg_split = '0;
    logic [NUM_PORTS-1:0]        pause = '0;
    logic                        cmp_valid = 1'b0;
    logic [NUM_PORTS*DATA_W-1:0] dut_a = '0;
    logic [NUM_PORTS*DATA_W-1:0] dut_b = '0;
    logic [NUM_PORTS*DATA_W-1:0] data_out;
    logic [NUM_PORTS-1:0]        valid_out;
    logic                        busy;
    logic                        done;
    logic                        error;
    logic [7:0]                  mismatch_cnt;
    logic [2:0]                  fsm_state;

    traffic_checker dut (
        .clk          (clk),
        .reset_L      (reset_L),
        .init         (init),
        .cfg_words    (cfg_words),
        .cfg_split    (cfg_split),
        .pause        (pause),
        .cmp_valid    (cmp_valid),
        .dut_a        (dut_a),
        .dut_b        (dut_b),
        .data_out     (data_out),
        .valid_out    (valid_out),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .mismatch_cnt (mismatch_cnt),
        .fsm_state    (fsm_state)
    );

    // ---------------- scoreboard ----------------
    logic [DATA_W-1:0] exp_q0[$];
    logic [DATA_W-1:0] exp_q1[$];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected word: VC bit from the split point, payload p*13+k wrapped to 5 bits.
    function automatic logic [DATA_W-1:0] exp_word(input int p, input int k, input int split);
        int pay;
        pay = (p * 13 + k) % 32;
        return {(k >= split) ? 1'b1 : 1'b0, pay[4:0]};
    endfunction

    task automatic push_model(input int words, input int split);
        for (int k = 0; k < words; k++) begin
            exp_q0.push_back(exp_word(0, k, split));
            exp_q1.push_back(exp_word(1, k, split));
        end
    endtask

    // Monitor: pop and compare whenever a port presents a valid word.
    always @(negedge clk) begin
        if (reset_L) begin
            if (valid_out[0]) begin
                if (exp_q0.size() == 0) check("p0_extra_word", int'(valid_out[0]), 0);
                else check("p0_word", int'(data_out[5:0]), int'(exp_q0.pop_front()));
            end
            if (valid_out[1]) begin
                if (exp_q1.size() == 0) check("p1_extra_word", int'(valid_out[1]), 0);
                else check("p1_word", int'(data_out[11:6]), int'(exp_q1.pop_front()));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic pulse_init(input int words, input int split);
        @(negedge clk);
        cfg_words = CNT_W'(words);
        cfg_split = CNT_W'(split);
        init      = 1'b1;
        @(negedge clk);
        init = 1'b0;
        check("state_init", int'(fsm_state), int'(S_INIT));
        check("busy_in_init", int'(busy), 1);
    endtask

    // Runs until done, counting per-state cycles. Optionally pauses port 1
    // for the first pause1_len SEND cycles.
    task automatic run_until_done(input int budget, input int pause1_len,
                                  output int drain_c, output int send_c,
                                  output int v0_c, output int v1_c);
        int left;
        left = pause1_len;
        drain_c = 0; send_c = 0; v0_c = 0; v1_c = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) break;
            if (fsm_state == S_DRAIN) drain_c++;
            if (fsm_state == S_SEND) send_c++;
            v0_c += int'(valid_out[0]);
            v1_c += int'(valid_out[1]);
            if (fsm_state == S_SEND && left > 0) begin
                pause[1] = 1'b1;
                left--;
            end else begin
                pause[1] = 1'b0;
            end
        end
        pause = '0;
        check("done_reached", int'(done), 1);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin
        int dc, sc, v0, v1;
        bit seen;

        // Reset
        #1 reset_L = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_data_out", int'(data_out), 0);
        check("rst_valid_out", int'(valid_out), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_error", int'(error), 0);
        check("rst_mismatch", int'(mismatch_cnt), 0);
        check("rst_state", int'(fsm_state), int'(S_IDLE));
        reset_L = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_after_reset", int'(fsm_state), int'(S_IDLE));
        check("idle_not_busy", int'(busy), 0);

        // Basic run. dut_a/dut_b differ but cmp_valid=0, so nothing may count.
        dut_a = '0;
        dut_b = 12'hFFF;
        exp_q0.push_back(6'h00); exp_q0.push_back(6'h01); exp_q0.push_back(6'h22);
        exp_q1.push_back(6'h0D); exp_q1.push_back(6'h0E); exp_q1.push_back(6'h2F);
        pulse_init(3, 2);
        run_until_done(50, 0, dc, sc, v0, v1);
        check("a_drain_cycles", dc, 4);
        check("a_send_cycles", sc, 4);
        check("a_p0_valid_cnt", v0, 3);
        check("a_p1_valid_cnt", v1, 3);
        check("a_q0_empty", exp_q0.size(), 0);
        check("a_q1_empty", exp_q1.size(), 0);
        check("a_busy_at_done", int'(busy), 0);
        check("a_no_cmp_count", int'(mismatch_cnt), 0);

        // Port 1 paused for two SEND cycles; restart straight from DONE.
        exp_q0.push_back(6'h00); exp_q0.push_back(6'h01); exp_q0.push_back(6'h22);
        exp_q1.push_back(6'h0D); exp_q1.push_back(6'h0E); exp_q1.push_back(6'h2F);
        pulse_init(3, 2);
        run_until_done(50, 2, dc, sc, v0, v1);
        check("b_send_cycles", sc, 6);
        check("b_drain_cycles", dc, 4);
        check("b_p0_valid_cnt", v0, 3);
        check("b_p1_valid_cnt", v1, 3);
        check("b_q0_empty", exp_q0.size(), 0);
        check("b_q1_empty", exp_q1.size(), 0);

        // Mismatch counting and saturation (in DONE).
        cmp_valid = 1'b1;
        repeat (3) @(negedge clk);
        check("c_cnt_after_3", int'(mismatch_cnt), 6);
        check("c_error_set", int'(error), 1);
        dut_b = 12'h001;
        @(negedge clk);
        check("c_cnt_one_port", int'(mismatch_cnt), 7);
        dut_b = 12'hFFF;
        repeat (200) @(negedge clk);
        check("c_cnt_saturated", int'(mismatch_cnt), 255);
        check("c_error_sticky", int'(error), 1);
        cmp_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("c_cnt_hold", int'(mismatch_cnt), 255);

        // init clears the counters even with a live compare; cfg_words=0 run.
        cfg_words = '0;
        cfg_split = '0;
        init      = 1'b1;
        cmp_valid = 1'b1;
        @(negedge clk);
        init = 1'b0;
        check("d_state_init", int'(fsm_state), int'(S_INIT));
        @(negedge clk);
        check("d_cnt_cleared", int'(mismatch_cnt), 0);
        check("d_error_cleared", int'(error), 0);
        check("d_state_drain", int'(fsm_state), int'(S_DRAIN));
        cmp_valid = 1'b0;
        run_until_done(20, 0, dc, sc, v0, v1);
        check("d_drain_cycles", dc + 1, 4);
        check("d_send_cycles", sc, 0);
        check("d_no_valid", v0 + v1, 0);
        check("d_cnt_stays_0", int'(mismatch_cnt), 0);

        // Reset in the middle of SEND, then restart with split=0 (all VC1).
        push_model(3, 2);
        pulse_init(3, 2);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (valid_out != '0) seen = 1'b1;
        end
        check("e_send_started", int'(valid_out != '0), 1);
        #2 reset_L = 1'b0;
        #1;
        check("e_rst_data_out", int'(data_out), 0);
        check("e_rst_valid_out", int'(valid_out), 0);
        check("e_rst_busy", int'(busy), 0);
        check("e_rst_state", int'(fsm_state), int'(S_IDLE));
        exp_q0.delete();
        exp_q1.delete();
        @(negedge clk);
        reset_L = 1'b1;
        repeat (3) @(negedge clk);
        check("e_idle_after_release", int'(fsm_state), int'(S_IDLE));
        push_model(2, 0);
        pulse_init(2, 0);
        run_until_done(50, 0, dc, sc, v0, v1);
        check("e_p0_valid_cnt", v0, 2);
        check("e_q0_empty", exp_q0.size(), 0);
        check("e_q1_empty", exp_q1.size(), 0);

        // Long run: port 1 payload wraps 0x1F -> 0x00 at k=19, all VC0.
        push_model(20, 25);
        pulse_init(20, 25);
        run_until_done(100, 0, dc, sc, v0, v1);
        check("f_p1_valid_cnt", v1, 20);
        check("f_q0_empty", exp_q0.size(), 0);
        check("f_q1_empty", exp_q1.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/traffic_checker.md
TRAFFIC_CHECKER -- requirements
Module: traffic_checker

Interface
REQ-001 Parameter DATA_W, default 6, width of one port data word; the MSB carries the VC bit.
REQ-002 Parameter NUM_PORTS, default 2, number of independent stimulus/compare ports (1..8).
REQ-003 Parameter CNT_W, default 5, width of cfg_words, cfg_split and per-port word counters.
REQ-004 Parameter PORT_OFFSET, default 13, per-port payload start offset.
REQ-005 Parameter DRAIN_CYC, default 4, cycles spent in DRAIN after the last word.
REQ-006 clk  input  1  single clock; all state on rising edge.
REQ-007 reset_L  input  1  asynchronous, active-low reset.
REQ-008 init  input  1  start pulse.
REQ-009 cfg_words  input  CNT_W  words to send per port; sampled in INIT.
REQ-010 cfg_split  input  CNT_W  word index where VC bit switches 0->1; sampled in INIT.
REQ-011 pause  input  NUM_PORTS  per-port backpressure.
REQ-012 data_out  output  NUM_PORTS*DATA_W  stimulus words; port p at bits [p*DATA_W +: DATA_W].
REQ-013 valid_out  output  NUM_PORTS  per-port word valid.
REQ-014 cmp_valid  input  1  dut_a/dut_b are comparable this cycle.
REQ-015 dut_a, dut_b  input  NUM_PORTS*DATA_W each  behavioural and structural DUT outputs.
REQ-016 busy  output  1  high in INIT, SEND, DRAIN.
REQ-017 done  output  1  high in DONE.
REQ-018 error  output  1  sticky mismatch flag.
REQ-019 mismatch_cnt  output  8  saturating mismatch count.

Function
REQ-020 FSM states IDLE, INIT, SEND, DRAIN, DONE; all outputs registered.
REQ-021 IDLE -> INIT when init=1; INIT lasts exactly one cycle, latches cfg_words/cfg_split, clears word counters, mismatch_cnt, error.
REQ-022 INIT -> SEND if latched cfg_words != 0, else INIT -> DRAIN.
REQ-023 In SEND, port p with counter k < cfg_words and pause[p]=0 drives valid_out[p]=1 next cycle with payload (p*PORT_OFFSET + k) mod 2^(DATA_W-1) and VC bit = (k >= cfg_split); k then increments.
REQ-024 pause[p]=1, or k = cfg_words: valid_out[p]=0, data_out for port p holds last value, k unchanged; ports are independent.
REQ-025 SEND -> DRAIN on the cycle after all ports reach k = cfg_words; DRAIN lasts DRAIN_CYC cycles, then DONE.
REQ-026 DONE holds until init=1, then -> INIT (restart); init in INIT/SEND/DRAIN is ignored.
REQ-027 Compare active in every state: on a cycle with cmp_valid=1, mismatch_cnt adds the number of ports whose dut_a and dut_b slices differ, saturating at 255; error sets if that number is nonzero.
REQ-028 cmp_valid=0: no count change; a compare in the INIT cycle is discarded (clear wins).
REQ-029 cfg_split >= cfg_words: all words VC0; cfg_split=0: all words VC1.
REQ-030 Payload wraps modulo 2^(DATA_W-1) without affecting the VC bit.

Reset
REQ-031 reset_L=0 at any time, including mid-SEND: state IDLE, data_out=0, valid_out=0, busy=0, done=0, error=0, mismatch_cnt=0, counters 0, asynchronously.
REQ-032 After reset_L rises, no activity until init=1 is sampled.

Verification
REQ-033 Defaults, cfg_words=3, cfg_split=2, pause=0, init pulse -> port0 emits 0x00,0x01,0x22; port1 0x0D,0x0E,0x2F; then 4 DRAIN cycles; done=1.
REQ-034 Same config, pause[1]=1 for 2 cycles during SEND -> port1 stalls 2 cycles with valid_out[1]=0, no words lost; SEND ends when port1 finishes.
REQ-035 cmp_valid=1, dut_a/dut_b differ on both ports for 200 cycles -> mismatch_cnt saturates at 255, error=1; the next init clears both.
REQ-036 cfg_words=0 -> INIT, DRAIN(4), DONE; valid_out never asserted.
REQ-037 reset_L low mid-SEND -> all outputs 0 immediately; after release, a new init restarts from k=0.
REQ-038 Port 1 payload with PORT_OFFSET=13, cfg_words=20 -> wraps 0x1F -> 0x00 at k=19, VC bit unaffected.
